// File: rtl/ball_collision_resolver_pkg.sv
// Shared types and constants for the ball collision resolver: bumper reflection
// factors, FSM states and the wall integration helper.
package ball_collision_resolver_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BALL_SIZE = 32;
  localparam int SPEED_W   = 11;
  localparam int PIX_W     = 11;
  localparam int POS_W     = 17;
  localparam int PROD_W    = 16;

  typedef struct packed {
    logic signed [3:0] xx;
    logic signed [3:0] yy;
    logic signed [3:0] xy;
    logic signed [3:0] yx;
  } COLLISION_FACTOR;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    APPLY,
    MOVE
  } state_e;

  typedef struct packed {
    logic signed [POS_W-1:0]   pos;
    logic signed [SPEED_W-1:0] speed;
  } axis_t;

  // One axis step: integrate, then clamp to [0, maxPix] and force the speed to point back inside.
  function automatic axis_t integrateAxis(
    input logic signed [POS_W-1:0]   pos,
    input logic signed [SPEED_W-1:0] speed,
    input int                        maxPix,
    input int                        fixedPoint
  );
    logic signed [POS_W-1:0]   newPos;
    logic signed [SPEED_W-1:0] mag;
    axis_t                     r;
    newPos  = pos + POS_W'(speed);
    mag     = speed[SPEED_W-1] ? -speed : speed;
    r.pos   = newPos;
    r.speed = speed;
    if (newPos[POS_W-1]) begin
      r.pos   = '0;
      r.speed = mag;
    end else if (int'(newPos >>> fixedPoint) > maxPix) begin
      r.pos   = POS_W'(maxPix << fixedPoint);
      r.speed = -mag;
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_collision_resolver_velocity_reflect.sv
// Combinational bumper reflection: 2x2 factor matrix times velocity, fixed-point
// shift, plus symmetric speed saturation for the registered result.
module ball_collision_resolver_velocity_reflect
  import ball_collision_resolver_pkg::*;
#(
  parameter int FACTOR_SHIFT = 1,
  parameter int MAX_SPEED    = 400
) (
  input  COLLISION_FACTOR           factor_i,
  input  logic signed [SPEED_W-1:0] vx_i,
  input  logic signed [SPEED_W-1:0] vy_i,
  output logic signed [PROD_W-1:0]  nx_o,
  output logic signed [PROD_W-1:0]  ny_o,
  input  logic signed [PROD_W:0]    rawX_i,
  input  logic signed [PROD_W:0]    rawY_i,
  output logic signed [SPEED_W-1:0] satX_o,
  output logic signed [SPEED_W-1:0] satY_o
);

  logic signed [PROD_W-1:0] xx, yy, xy, yx, vx, vy, sumX, sumY;

  function automatic logic signed [SPEED_W-1:0] clampSpeed(input logic signed [PROD_W:0] v);
    logic signed [SPEED_W-1:0] r;
    if (int'(v) > MAX_SPEED) begin
      r = SPEED_W'(MAX_SPEED);
    end else if (int'(v) < -MAX_SPEED) begin
      r = SPEED_W'(-MAX_SPEED);
    end else begin
      r = SPEED_W'(v);
    end
    return r;
  endfunction

  always_comb begin
    xx   = PROD_W'($signed(factor_i.xx));
    yy   = PROD_W'($signed(factor_i.yy));
    xy   = PROD_W'($signed(factor_i.xy));
    yx   = PROD_W'($signed(factor_i.yx));
    vx   = PROD_W'(vx_i);
    vy   = PROD_W'(vy_i);
    sumX = xx * vx + xy * vy;
    sumY = yx * vx + yy * vy;
    nx_o = sumX >>> FACTOR_SHIFT;
    ny_o = sumY >>> FACTOR_SHIFT;
  end

  assign satX_o = clampSpeed(rawX_i);
  assign satY_o = clampSpeed(rawY_i);

endmodule

// File: rtl/ball_collision_resolver.sv
// Ball physics per frame: latch the first ball/bumper overlap, reflect the velocity
// at frame start, add gravity, saturate, integrate position and bounce off walls.
module ball_collision_resolver
  import ball_collision_resolver_pkg::*;
#(
  parameter int INIT_X       = 64,
  parameter int INIT_Y       = 64,
  parameter int INIT_SPEED_X = 40,
  parameter int INIT_SPEED_Y = 0,
  parameter int GRAVITY      = 4,
  parameter int MAX_SPEED    = 400,
  parameter int FACTOR_SHIFT = 1,
  parameter int FIXED_POINT  = 6,
  parameter int COOLDOWN     = 4,
  parameter int MAX_X        = SCREEN_W - BALL_SIZE - 1,
  parameter int MAX_Y        = SCREEN_H - BALL_SIZE - 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      startOfFrame_i,
  input  logic                      drawBall_i,
  input  logic                      drawBumper_i,
  input  COLLISION_FACTOR           collisionFactor_i,
  output logic signed [PIX_W-1:0]   topLeftX_o,
  output logic signed [PIX_W-1:0]   topLeftY_o,
  output logic signed [SPEED_W-1:0] speedX_o,
  output logic signed [SPEED_W-1:0] speedY_o,
  output logic                      busy_o
);

  localparam int CD_W = $clog2(COOLDOWN + 1);
  localparam logic signed [POS_W-1:0]  INIT_POS_X = POS_W'(INIT_X * (1 << FIXED_POINT));
  localparam logic signed [POS_W-1:0]  INIT_POS_Y = POS_W'(INIT_Y * (1 << FIXED_POINT));
  localparam logic signed [PROD_W:0]   GRAV       = (PROD_W + 1)'(GRAVITY);

  state_e                    state_q, state_d;
  logic                      hitPending_q, hitPending_d;
  logic                      hitUse_q, hitUse_d;
  logic                      reflect_q, reflect_d;
  COLLISION_FACTOR           factor_q, factor_d;
  COLLISION_FACTOR           factorUse_q, factorUse_d;
  logic [CD_W-1:0]           cooldown_q, cooldown_d;
  logic signed [PROD_W-1:0]  nx_q, nx_d, ny_q, ny_d;
  logic signed [SPEED_W-1:0] speedX_q, speedX_d, speedY_q, speedY_d;
  logic signed [POS_W-1:0]   posX_q, posX_d, posY_q, posY_d;

  logic                      overlap;
  logic signed [PROD_W-1:0]  mulX, mulY;
  logic signed [PROD_W:0]    rawX, rawY;
  logic signed [SPEED_W-1:0] satX, satY;
  axis_t                     axisX, axisY;

  assign overlap = drawBall_i && drawBumper_i;
  assign rawX    = {nx_q[PROD_W-1], nx_q};
  assign rawY    = {ny_q[PROD_W-1], ny_q} + GRAV;
  assign axisX   = integrateAxis(posX_q, speedX_q, MAX_X, FIXED_POINT);
  assign axisY   = integrateAxis(posY_q, speedY_q, MAX_Y, FIXED_POINT);

  ball_collision_resolver_velocity_reflect #(
    .FACTOR_SHIFT (FACTOR_SHIFT),
    .MAX_SPEED    (MAX_SPEED)
  ) u_reflect (
    .factor_i (factorUse_q),
    .vx_i     (speedX_q),
    .vy_i     (speedY_q),
    .nx_o     (mulX),
    .ny_o     (mulY),
    .rawX_i   (rawX),
    .rawY_i   (rawY),
    .satX_o   (satX),
    .satY_o   (satY)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startOfFrame_i) state_d = CALC;
      CALC:    state_d = APPLY;
      APPLY:   state_d = MOVE;
      MOVE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // At frame start the pending hit moves into the working slot, so an overlap on
  // that same cycle refills the pending slot and is reflected one frame later.
  always_comb begin
    hitPending_d = hitPending_q;
    hitUse_d     = hitUse_q;
    reflect_d    = reflect_q;
    factor_d     = factor_q;
    factorUse_d  = factorUse_q;
    cooldown_d   = cooldown_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    speedX_d     = speedX_q;
    speedY_d     = speedY_q;
    posX_d       = posX_q;
    posY_d       = posY_q;
    case (state_q)
      IDLE: begin
        if (startOfFrame_i) begin
          hitUse_d     = hitPending_q;
          factorUse_d  = factor_q;
          hitPending_d = overlap;
          if (overlap) factor_d = collisionFactor_i;
        end else if (overlap && !hitPending_q) begin
          hitPending_d = 1'b1;
          factor_d     = collisionFactor_i;
        end
      end
      CALC: begin
        reflect_d = hitUse_q && (cooldown_q == '0);
        if (reflect_d) begin
          nx_d = mulX;
          ny_d = mulY;
        end else begin
          nx_d = PROD_W'(speedX_q);
          ny_d = PROD_W'(speedY_q);
        end
      end
      APPLY: begin
        speedX_d = satX;
        speedY_d = satY;
        hitUse_d = 1'b0;
        if (reflect_q) begin
          cooldown_d = CD_W'(COOLDOWN);
        end else if (cooldown_q != '0) begin
          cooldown_d = cooldown_q - CD_W'(1);
        end
      end
      MOVE: begin
        posX_d   = axisX.pos;
        speedX_d = axisX.speed;
        posY_d   = axisY.pos;
        speedY_d = axisY.speed;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      hitPending_q <= 1'b0;
      hitUse_q     <= 1'b0;
      reflect_q    <= 1'b0;
      factor_q     <= '0;
      factorUse_q  <= '0;
      cooldown_q   <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      speedX_q     <= SPEED_W'(INIT_SPEED_X);
      speedY_q     <= SPEED_W'(INIT_SPEED_Y);
      posX_q       <= INIT_POS_X;
      posY_q       <= INIT_POS_Y;
    end else begin
      state_q      <= state_d;
      hitPending_q <= hitPending_d;
      hitUse_q     <= hitUse_d;
      reflect_q    <= reflect_d;
      factor_q     <= factor_d;
      factorUse_q  <= factorUse_d;
      cooldown_q   <= cooldown_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      speedX_q     <= speedX_d;
      speedY_q     <= speedY_d;
      posX_q       <= posX_d;
      posY_q       <= posY_d;
    end
  end

  assign topLeftX_o = PIX_W'(posX_q >>> FIXED_POINT);
  assign topLeftY_o = PIX_W'(posY_q >>> FIXED_POINT);
  assign speedX_o   = speedX_q;
  assign speedY_o   = speedY_q;
  assign busy_o     = (state_q != IDLE);

endmodule
